// File: rtl/arbitro_rr_pkg.sv
// Shared definitions for the four-queue egress path: queue count, FSM encoding
// and a small one-hot helper used by the arbiter and its benches.
package arbitro_rr_pkg;

  localparam int NUM_COLAS = 4;
  localparam int IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACTIVO   = 2'b01,
    PAUSA    = 2'b10,
    INVALIDO = 2'b11
  } estado_e;

  function automatic logic [NUM_COLAS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_COLAS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/arbitro_rr_prioridad.sv
// Rotated priority encoder: first set request bit scanning puntero_i,
// puntero_i+1, ... modulo the number of queues.
module prioridad_rr
  import arbitro_rr_pkg::*;
(
  input  logic [NUM_COLAS-1:0] req_i,
  input  logic [IDX_W-1:0]     puntero_i,
  output logic                 valido_o,
  output logic [IDX_W-1:0]     indice_o
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valido_o = 1'b0;
    indice_o = puntero_i;
    idx      = puntero_i;
    for (int k = NUM_COLAS - 1; k >= 0; k--) begin
      idx = puntero_i + IDX_W'(k);
      if (req_i[idx]) begin
        valido_o = 1'b1;
        indice_o = idx;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter feeding the 4:1 egress mux: pops one upstream queue per
// cycle and pushes the selected word into the downstream FIFO.
module arbitro_rr #(
  parameter int NUM_COLAS = 4,
  parameter int CONT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [NUM_COLAS-1:0] fifo_vacio,
  input  logic                 fifo_casi_lleno_sal,
  output logic [NUM_COLAS-1:0] pop,
  output logic                 push,
  output logic [1:0]           selector,
  output logic                 enb,
  output logic [1:0]           estado,
  output logic [CONT_BITS-1:0] cont_grant0,
  output logic [CONT_BITS-1:0] cont_grant1,
  output logic [CONT_BITS-1:0] cont_grant2,
  output logic [CONT_BITS-1:0] cont_grant3
);
  import arbitro_rr_pkg::*;

  // Handshake: pop[g] and push are one-cycle strobes; the upstream FIFO g and
  // the downstream FIFO both act on the edge that ends the strobe cycle, and
  // the mux reads selector/enb combinationally during that same cycle.

  localparam logic [CONT_BITS-1:0] CONT_MAX = {CONT_BITS{1'b1}};

  estado_e                estado_q, estado_d;
  logic [1:0]             puntero_q, puntero_d;
  logic [1:0]             ultimo_q, ultimo_d;
  logic                   ultimo_vld_q, ultimo_vld_d;
  logic [NUM_COLAS-1:0]   pop_q, pop_d;
  logic                   push_q, push_d;
  logic [1:0]             selector_q, selector_d;
  logic [CONT_BITS-1:0]   cont_q [NUM_COLAS];
  logic [CONT_BITS-1:0]   cont_d [NUM_COLAS];

  logic                   hay_datos;
  logic [NUM_COLAS-1:0]   excluida;
  logic [NUM_COLAS-1:0]   req;
  logic                   gnt_vld;
  logic [1:0]             gnt_idx;
  logic                   grant;

  assign hay_datos = ~&fifo_vacio;

  // The last granted queue still looks non-empty for one cycle after its pop.
  assign excluida = ultimo_vld_q ? onehot(ultimo_q) : '0;
  assign req      = ~fifo_vacio & ~excluida;

  prioridad_rr u_prioridad (
    .req_i     (req),
    .puntero_i (puntero_q),
    .valido_o  (gnt_vld),
    .indice_o  (gnt_idx)
  );

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE: begin
        if (hay_datos) begin
          estado_d = fifo_casi_lleno_sal ? PAUSA : ACTIVO;
        end
      end
      ACTIVO: begin
        if (fifo_casi_lleno_sal) begin
          estado_d = PAUSA;
        end else if (!hay_datos) begin
          estado_d = IDLE;
        end
      end
      PAUSA: begin
        if (!fifo_casi_lleno_sal) begin
          estado_d = hay_datos ? ACTIVO : IDLE;
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  // Only an edge that lands in ACTIVO may grant; almost-full never lands there.
  assign grant = (estado_d == ACTIVO) && gnt_vld;

  always_comb begin
    pop_d        = '0;
    push_d       = 1'b0;
    selector_d   = selector_q;
    puntero_d    = puntero_q;
    ultimo_d     = ultimo_q;
    ultimo_vld_d = 1'b0;
    for (int i = 0; i < NUM_COLAS; i++) begin
      cont_d[i] = cont_q[i];
    end
    if (grant) begin
      pop_d        = onehot(gnt_idx);
      push_d       = 1'b1;
      selector_d   = gnt_idx;
      puntero_d    = gnt_idx + 2'd1;
      ultimo_d     = gnt_idx;
      ultimo_vld_d = 1'b1;
      for (int i = 0; i < NUM_COLAS; i++) begin
        if ((gnt_idx == 2'(i)) && (cont_q[i] != CONT_MAX)) begin
          cont_d[i] = cont_q[i] + CONT_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      estado_q     <= IDLE;
      puntero_q    <= '0;
      ultimo_q     <= '0;
      ultimo_vld_q <= 1'b0;
      pop_q        <= '0;
      push_q       <= 1'b0;
      selector_q   <= '0;
      for (int i = 0; i < NUM_COLAS; i++) begin
        cont_q[i] <= '0;
      end
    end else begin
      estado_q     <= estado_d;
      puntero_q    <= puntero_d;
      ultimo_q     <= ultimo_d;
      ultimo_vld_q <= ultimo_vld_d;
      pop_q        <= pop_d;
      push_q       <= push_d;
      selector_q   <= selector_d;
      for (int i = 0; i < NUM_COLAS; i++) begin
        cont_q[i] <= cont_d[i];
      end
    end
  end

  assign pop         = pop_q;
  assign push        = push_q;
  assign enb         = push_q;
  assign selector    = selector_q;
  assign estado      = estado_q;
  assign cont_grant0 = cont_q[0];
  assign cont_grant1 = cont_q[1];
  assign cont_grant2 = cont_q[2];
  assign cont_grant3 = cont_q[3];

endmodule

// File: tb/tb_arbitro_rr.sv
// Bench for arbitro_rr: word-count models of the upstream queues, a
// rule-level arbiter model checked every cycle, and directed scenarios.
module tb_arbitro_rr;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [3:0] fifo_vacio;
  logic       fifo_casi_lleno_sal;

  logic [3:0] pop, pop_s;
  logic       push, push_s, enb, enb_s;
  logic [1:0] selector, selector_s, estado, estado_s;
  logic [7:0] cg0, cg1, cg2, cg3;
  logic [1:0] cs0, cs1, cs2, cs3;

  always #5 clk = ~clk;

  arbitro_rr #(.NUM_COLAS(4), .CONT_BITS(8)) dut (
    .clk(clk), .reset_L(reset_L), .fifo_vacio(fifo_vacio),
    .fifo_casi_lleno_sal(fifo_casi_lleno_sal), .pop(pop), .push(push),
    .selector(selector), .enb(enb), .estado(estado),
    .cont_grant0(cg0), .cont_grant1(cg1), .cont_grant2(cg2), .cont_grant3(cg3)
  );

  arbitro_rr #(.NUM_COLAS(4), .CONT_BITS(2)) dut_s (
    .clk(clk), .reset_L(reset_L), .fifo_vacio(fifo_vacio),
    .fifo_casi_lleno_sal(fifo_casi_lleno_sal), .pop(pop_s), .push(push_s),
    .selector(selector_s), .enb(enb_s), .estado(estado_s),
    .cont_grant0(cs0), .cont_grant1(cs1), .cont_grant2(cs2), .cont_grant3(cs3)
  );

  int         n_vec = 0;
  int         n_err = 0;
  bit         chk_en = 1'b0;
  int         cnt [4];
  logic [3:0] pend;
  logic       rst_v, afull_v;
  logic [1:0] log_q [$];
  logic [1:0] exp_q [$];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Arbiter model: rules stated directly, queues as integers.
  int m_state = 0, m_ptr = 0, m_last = -1, m_pop = 0, m_push = 0, m_sel = 0;
  int m_cnt [4] = '{0, 0, 0, 0};
  int m_nxt, m_g, m_q;
  bit m_any;

  always @(posedge clk) begin
    if (!reset_L) begin
      m_state = 0; m_ptr = 0; m_last = -1; m_pop = 0; m_push = 0; m_sel = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      m_any = (fifo_vacio != 4'hF);
      if (fifo_casi_lleno_sal) m_nxt = (m_state == 0 && !m_any) ? 0 : 2;
      else                     m_nxt = m_any ? 1 : 0;
      m_g = -1;
      if (m_nxt == 1) begin
        for (int off = 0; off < 4; off++) begin
          m_q = (m_ptr + off) % 4;
          if (m_g < 0 && !fifo_vacio[m_q] && m_q != m_last) m_g = m_q;
        end
      end
      if (m_g >= 0) begin
        m_pop = 1 << m_g; m_push = 1; m_sel = m_g;
        m_ptr = (m_g + 1) % 4; m_last = m_g; m_cnt[m_g]++;
      end else begin
        m_pop = 0; m_push = 0; m_last = -1;
      end
      m_state = m_nxt;
    end
  end

  function automatic int cap(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("pop", pop, m_pop);
      check("push", push, m_push);
      check("enb", enb, m_push);
      check("selector", selector, m_sel);
      check("estado", estado, m_state);
      check("cont_grant0", cg0, cap(m_cnt[0], 255));
      check("cont_grant1", cg1, cap(m_cnt[1], 255));
      check("cont_grant2", cg2, cap(m_cnt[2], 255));
      check("cont_grant3", cg3, cap(m_cnt[3], 255));
      check("sat_pop", pop_s, m_pop);
      check("sat_cont0", cs0, cap(m_cnt[0], 3));
      check("sat_cont1", cs1, cap(m_cnt[1], 3));
      check("sat_cont2", cs2, cap(m_cnt[2], 3));
      check("sat_cont3", cs3, cap(m_cnt[3], 3));
    end
  end

  task automatic drive_now();
    for (int i = 0; i < 4; i++) fifo_vacio[i] = (cnt[i] == 0);
    fifo_casi_lleno_sal = afull_v;
    reset_L = rst_v;
  endtask

  // One edge: log the word pushed, retire pops that the FIFOs took at this
  // edge, then drive the next inputs.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (push) log_q.push_back(selector);
    for (int i = 0; i < 4; i++) if (pend[i] && cnt[i] > 0) cnt[i]--;
    pend = pop;
    drive_now();
  endtask

  task automatic set_cnt(input int c0, input int c1, input int c2, input int c3);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
  endtask

  task automatic do_reset();
    rst_v = 1'b0; afull_v = 1'b0; pend = '0;
    set_cnt(1000, 1000, 1000, 1000);
    drive_now();
    tick();
    chk_en = 1'b1;
    tick();
    rst_v = 1'b1;
    log_q.delete();
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check(name, log_q[i], exp_q[i]);
  endtask

  initial begin
    rst_v = 1'b0; afull_v = 1'b0; pend = '0;
    set_cnt(1000, 1000, 1000, 1000);
    drive_now();

    // Reset with every queue non-empty.
    do_reset();
    check("rst_pop", pop, 0);
    check("rst_push", push, 0);
    check("rst_selector", selector, 0);
    check("rst_estado", estado, 0);
    check("rst_cont", cg0 + cg1 + cg2 + cg3, 0);

    // Fair rotation.
    drive_now();
    for (int k = 0; k < 8; k++) tick();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    check_log("rot_seq");
    check("rot_c0", cg0, 2); check("rot_c1", cg1, 2);
    check("rot_c2", cg2, 2); check("rot_c3", cg3, 2);

    // Single queue with three words: alternate-cycle pops, then IDLE.
    do_reset();
    set_cnt(0, 0, 3, 0);
    drive_now();
    tick();
    check("single_pop1", pop, 4);
    tick();
    check("single_gap", pop, 0);
    for (int k = 0; k < 6; k++) tick();
    exp_q = '{2'd2, 2'd2, 2'd2};
    check_log("single_seq");
    check("single_idle", estado, 0);
    check("single_c2", cg2, 3);

    // Backpressure mid-stream, then resume at the saved pointer.
    do_reset();
    drive_now();
    for (int k = 0; k < 3; k++) tick();
    afull_v = 1'b1; drive_now();
    tick();
    check("bp_push", push, 0);
    check("bp_estado", estado, 2);
    tick();
    check("bp_hold", push, 0);
    afull_v = 1'b0; drive_now();
    tick(); tick();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    check_log("bp_seq");

    // Reset while a grant is on the outputs.
    rst_v = 1'b0; drive_now();
    tick();
    check("midrst_pop", pop, 0);
    check("midrst_push", push, 0);
    check("midrst_sel", selector, 0);
    check("midrst_c0", cg0, 0);

    // Skip empties starting from puntero=1.
    do_reset();
    set_cnt(1000, 0, 0, 0);
    drive_now();
    tick();
    cnt[2] = 1000; drive_now();
    check("skip_vacio", fifo_vacio, 4'b1010);
    tick(); tick(); tick();
    exp_q = '{2'd0, 2'd2, 2'd0, 2'd2};
    check_log("skip_seq");

    // Saturation: five grants to queue 0.
    do_reset();
    set_cnt(5, 0, 0, 0);
    drive_now();
    for (int k = 0; k < 11; k++) tick();
    check("sat_c0_2bit", cs0, 3);
    check("sat_c0_8bit", cg0, 5);
    check("sat_pushes", log_q.size(), 5);

    // Almost-full with all queues empty: IDLE holds, ACTIVO goes to PAUSA.
    do_reset();
    set_cnt(0, 0, 0, 0); afull_v = 1'b1;
    drive_now();
    tick();
    check("idle_afull", estado, 0);
    set_cnt(1000, 1000, 1000, 1000); afull_v = 1'b0;
    drive_now();
    tick();
    check("act_enter", estado, 1);
    set_cnt(0, 0, 0, 0); afull_v = 1'b1;
    drive_now();
    tick();
    check("act_afull_empty", estado, 2);
    check("act_afull_push", push, 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
